fetch: RTL and testbench

FETCH -- requirements
Module: fetch

---
 rtl/fetch.sv | 180 ++++++++++++++++++
 tb/tb_fetch.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch.sv
// -----------------------------------------------------------------------------
// fetch -- instruction fetch unit with a 2-entry prefetch buffer.
//
// Issues one instruction-memory request at a time, queues the returned
// {instr, imm, pred} words in a 2-entry FIFO and hands them to decode as a
// registered one-cycle submit pulse. A flush redirects the PC, empties the
// FIFO and discards the data of any request still in flight.
//
// Configuration:
//   FETCH_BRANCH_PRED_EN  defined: predict JMP (opcode 0x0E, cond 0) and JAL
//                         (opcode 0x0F) as taken, redirecting to the immediate.
//                         undefined: never predict; the PC always increments.
//
// Ports:
//   i_clk, i_rst          clock; synchronous active-high reset
//   o_mem_req/o_mem_addr  word-address request, held until i_mem_ack
//   i_mem_ack/i_mem_data  one-cycle acknowledge with {imm, instr}
//   o_instr/o_imm         instruction and immediate presented to decode
//   o_jmp_pred            instruction was predicted taken
//   o_submit              one-cycle valid pulse for the three outputs above
//   i_next_ready          decode can accept a submit
//   i_flush/i_flush_pc    pipeline flush and redirect target
// -----------------------------------------------------------------------------
module fetch (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_mem_req,
    output logic [15:0] o_mem_addr,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_data,
    output logic [15:0] o_instr,
    output logic [15:0] o_imm,
    output logic        o_jmp_pred,
    output logic        o_submit,
    input  logic        i_next_ready,
    input  logic        i_flush,
    input  logic [15:0] i_flush_pc
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DISCARD
    } state_t;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] imm;
        logic        pred;
    } entry_t;

    state_t      state;
    logic [15:0] fpc;
    entry_t      fifo_q [2];   // [0] is the head
    logic [1:0]  count_q;

    logic        pred;
    entry_t      new_entry;
    logic        push;
    logic        pop;

    // NOTE: every signal driven from always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        pred = 1'b0;
`ifdef FETCH_BRANCH_PRED_EN
        if ((i_mem_data[6:0] == 7'h0E && i_mem_data[10:7] == 4'h0) ||
            (i_mem_data[6:0] == 7'h0F)) begin
            pred = 1'b1;
        end
`endif
    end

    always_comb begin
        new_entry.instr = i_mem_data[15:0];
        new_entry.imm   = i_mem_data[31:16];
        new_entry.pred  = pred;
    end

    // Only an ack to a live request fills the FIFO; a flush kills both the
    // push and the pop on its edge. A request is only issued with count < 2
    // and the count cannot rise while it is outstanding, so push never
    // meets a full FIFO.
    assign push = (state == ST_REQ) && i_mem_ack && !i_flush;
    assign pop  = (count_q != 2'd0) && i_next_ready && !i_flush;

    // NOTE: the FIFO payload has no reset; count_q alone defines which
    // entries are valid, so clearing the storage would buy nothing.
    always_ff @(posedge i_clk) begin
        if (push && pop) begin
            if (count_q == 2'd2) begin
                fifo_q[0] <= fifo_q[1];
                fifo_q[1] <= new_entry;
            end else begin
                fifo_q[0] <= new_entry;
            end
        end else if (pop) begin
            fifo_q[0] <= fifo_q[1];
        end else if (push) begin
            if (count_q == 2'd0) begin
                fifo_q[0] <= new_entry;
            end else begin
                fifo_q[1] <= new_entry;
            end
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            fpc        <= 16'h0000;
            count_q    <= 2'd0;
            o_mem_req  <= 1'b0;
            o_mem_addr <= 16'h0000;
            o_instr    <= 16'h0000;
            o_imm      <= 16'h0000;
            o_jmp_pred <= 1'b0;
            o_submit   <= 1'b0;
        end else begin
            // FIFO occupancy
            if (i_flush) begin
                count_q <= 2'd0;
            end else if (push && !pop) begin
                count_q <= count_q + 2'd1;
            end else if (pop && !push) begin
                count_q <= count_q - 2'd1;
            end

            // Submit to decode
            if (pop) begin
                o_instr    <= fifo_q[0].instr;
                o_imm      <= fifo_q[0].imm;
                o_jmp_pred <= fifo_q[0].pred;
                o_submit   <= 1'b1;
            end else begin
                o_submit   <= 1'b0;
            end

            // PC: a flush redirect beats the sequential/predicted update
            if (i_flush) begin
                fpc <= i_flush_pc;
            end else if (push) begin
                fpc <= pred ? i_mem_data[31:16] : fpc + 16'h0001;
            end

            // Request state machine. The address is latched on entry to REQ
            // so it stays stable through DISCARD even though fpc may move.
            case (state)
                ST_IDLE: begin
                    if (!i_flush && count_q < 2'd2) begin
                        state      <= ST_REQ;
                        o_mem_req  <= 1'b1;
                        o_mem_addr <= fpc;
                    end
                end
                ST_REQ: begin
                    if (i_mem_ack) begin
                        state     <= ST_IDLE;
                        o_mem_req <= 1'b0;
                    end else if (i_flush) begin
                        state     <= ST_DISCARD;
                    end
                end
                ST_DISCARD: begin
                    if (i_mem_ack) begin
                        state     <= ST_IDLE;
                        o_mem_req <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    o_mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch.sv
// -----------------------------------------------------------------------------
// tb_fetch -- directed self-checking bench for fetch.
// A behavioural memory acks each request after ack_delay idle cycles and logs
// the acknowledged address; a monitor logs every submit. Tests compare those
// logs and sampled outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_fetch;

    logic        clk;
    logic        i_rst;
    logic        o_mem_req;
    logic [15:0] o_mem_addr;
    logic        i_mem_ack;
    logic [31:0] i_mem_data;
    logic [15:0] o_instr;
    logic [15:0] o_imm;
    logic        o_jmp_pred;
    logic        o_submit;
    logic        i_next_ready;
    logic        i_flush;
    logic [15:0] i_flush_pc;

    int n_cmp;
    int n_err;

    // memory model controls and logs
    logic        mem_en;
    int          ack_delay;
    int          wait_cnt;
    int          ack_cnt;
    logic [15:0] addr_q [$];
    logic [32:0] sub_q  [$];   // {pred, imm, instr}

    fetch dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .o_mem_req    (o_mem_req),
        .o_mem_addr   (o_mem_addr),
        .i_mem_ack    (i_mem_ack),
        .i_mem_data   (i_mem_data),
        .o_instr      (o_instr),
        .o_imm        (o_imm),
        .o_jmp_pred   (o_jmp_pred),
        .o_submit     (o_submit),
        .i_next_ready (i_next_ready),
        .i_flush      (i_flush),
        .i_flush_pc   (i_flush_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [15:0] a);
        case (a)
            16'h0000: mem_rd = 32'h0005_0007;
            16'h0001: mem_rd = 32'h0000_0001;
            16'h0002: mem_rd = 32'h0100_000E;
            default:  mem_rd = 32'h0000_0001;
        endcase
    endfunction

    // Memory: responds on the falling edge so the ack is seen at the next rise.
    always @(negedge clk) begin
        i_mem_ack = 1'b0;
        if (mem_en && !i_rst && o_mem_req) begin
            if (wait_cnt >= ack_delay) begin
                i_mem_ack  = 1'b1;
                i_mem_data = mem_rd(o_mem_addr);
                addr_q.push_back(o_mem_addr);
                ack_cnt++;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    always @(negedge clk) begin
        if (!i_rst && o_submit) sub_q.push_back({o_jmp_pred, o_imm, o_instr});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] get_addr(input int i);
        get_addr = (i < addr_q.size()) ? {16'h0000, addr_q[i]} : 32'hDEAD_DEAD;
    endfunction

    function automatic logic [32:0] get_sub(input int i);
        get_sub = (i < sub_q.size()) ? sub_q[i] : 33'h1_DEAD_DEAD;
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Holds reset for two edges; returns at a falling edge with reset released.
    task automatic do_reset(input logic ready);
        i_rst        = 1'b1;
        i_flush      = 1'b0;
        i_flush_pc   = 16'h0000;
        i_next_ready = ready;
        mem_en       = 1'b1;
        ack_delay    = 0;
        step(2);
        addr_q.delete();
        sub_q.delete();
        ack_cnt = 0;
        i_rst   = 1'b0;
    endtask

    logic [15:0] exp_jmp_addr;
    logic        exp_pred;

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        wait_cnt   = 0;
        ack_cnt    = 0;
        i_mem_ack  = 1'b0;
        i_mem_data = 32'h0;
`ifdef FETCH_BRANCH_PRED_EN
        exp_jmp_addr = 16'h0100;
        exp_pred     = 1'b1;
`else
        exp_jmp_addr = 16'h0003;
        exp_pred     = 1'b0;
`endif

        // ---- reset state, first request, latency, in-order submits, prediction
        i_rst        = 1'b1;
        i_flush      = 1'b0;
        i_flush_pc   = 16'h0000;
        i_next_ready = 1'b1;
        mem_en       = 1'b1;
        ack_delay    = 0;
        step(2);
        check("rst_submit", {31'd0, o_submit}, 32'd0);
        check("rst_req",    {31'd0, o_mem_req}, 32'd0);
        check("rst_instr",  {16'd0, o_instr}, 32'd0);
        check("rst_imm",    {16'd0, o_imm}, 32'd0);
        check("rst_pred",   {31'd0, o_jmp_pred}, 32'd0);
        do_reset(1'b1);
        step(1);
        check("first_req",  {31'd0, o_mem_req}, 32'd1);
        check("first_addr", {16'd0, o_mem_addr}, 32'd0);
        step(1);
        check("lat_no_submit", {31'd0, o_submit}, 32'd0);
        step(1);
        check("lat_submit", {31'd0, o_submit}, 32'd1);
        check("sub0_instr", {16'd0, o_instr}, 32'h0007);
        check("sub0_imm",   {16'd0, o_imm}, 32'h0005);
        step(9);
        check("addr0", get_addr(0), 32'h0000);
        check("addr1", get_addr(1), 32'h0001);
        check("addr2", get_addr(2), 32'h0002);
        check("addr3_after_jmp", get_addr(3), {16'd0, exp_jmp_addr});
        check("sub0", get_sub(0)[31:0], 32'h0005_0007);
        check("sub1", get_sub(1)[31:0], 32'h0000_0001);
        check("sub2", get_sub(2)[31:0], 32'h0100_000E);
        check("sub2_pred", {31'd0, get_sub(2)[32]}, {31'd0, exp_pred});
        check("sub0_pred", {31'd0, get_sub(0)[32]}, 32'd0);

        // ---- decode stalled: FIFO fills with exactly two, then drains in order
        do_reset(1'b0);
        step(10);
        check("stall_acks", ack_cnt, 32'd2);
        check("stall_req_low", {31'd0, o_mem_req}, 32'd0);
        check("stall_no_submit", sub_q.size(), 32'd0);
        i_next_ready = 1'b1;
        step(4);
        check("drain0", get_sub(0)[31:0], 32'h0005_0007);
        check("drain1", get_sub(1)[31:0], 32'h0000_0001);

        // ---- flush while awaiting ack: data dropped, redirect to 0x0040
        do_reset(1'b1);
        ack_delay = 3;
        step(1);
        check("flush_in_req", {31'd0, o_mem_req}, 32'd1);
        i_flush    = 1'b1;
        i_flush_pc = 16'h0040;
        step(1);
        i_flush = 1'b0;
        check("discard_req_held", {31'd0, o_mem_req}, 32'd1);
        check("discard_addr_held", {16'd0, o_mem_addr}, 32'd0);
        step(3);
        check("discard_acked", ack_cnt, 32'd1);
        step(2);
        check("redirect_req", {31'd0, o_mem_req}, 32'd1);
        check("redirect_addr", {16'd0, o_mem_addr}, 32'h0040);
        check("discard_no_submit", sub_q.size(), 32'd0);

        // ---- PC wrap: flush to 0xFFFF, non-branch word, next address 0x0000
        do_reset(1'b1);
        i_flush    = 1'b1;
        i_flush_pc = 16'hFFFF;
        step(1);
        i_flush = 1'b0;
        step(6);
        check("wrap_addr_ffff", get_addr(0), 32'h0000_FFFF);
        check("wrap_addr_0",    get_addr(1), 32'h0000_0000);

        // ---- reset with a full FIFO and a submit in progress
        do_reset(1'b0);
        step(10);
        i_next_ready = 1'b1;
        step(1);
        check("pre_rst_submit", {31'd0, o_submit}, 32'd1);
        i_rst = 1'b1;
        step(1);
        check("mid_rst_submit", {31'd0, o_submit}, 32'd0);
        check("mid_rst_req",    {31'd0, o_mem_req}, 32'd0);
        check("mid_rst_instr",  {16'd0, o_instr}, 32'd0);
        mem_en = 1'b0;
        sub_q.delete();
        i_rst = 1'b0;
        step(3);
        check("post_rst_empty", sub_q.size(), 32'd0);
        check("post_rst_req",   {31'd0, o_mem_req}, 32'd1);
        check("post_rst_addr",  {16'd0, o_mem_addr}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
